sodor_imem_responder: RTL

//  Instruction-memory model driving the Core imem port; replaces the constant instruction/valid tie-off.

---
 rtl/sodor_imem_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sodor_imem_responder.sv
// Instruction-memory model for the Sodor core imem port.
// Accepts fetch requests, answers each one with a ROM word LATENCY cycles
// after accept, and lets the bench preload the ROM through a side load port.
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   io_imem_req_valid/_bits_addr fetch request (byte address)
//   io_imem_resp_valid/_bits_data registered one-cycle response pulse + word
//   load_en/load_addr/load_data  ROM write port (word index), always accepted
//   req_count                    requests accepted since reset (wraps)
//   miss_count                   NOP_INSN responses served (saturates)
module sodor_imem_responder #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned AW        = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] NOP_INSN  = 32'h0000_0013
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          io_imem_req_valid,
  input  logic [31:0]   io_imem_req_bits_addr,
  output logic          io_imem_resp_valid,
  output logic [31:0]   io_imem_resp_bits_data,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic [31:0]   req_count,
  output logic [15:0]   miss_count
);

  localparam int unsigned CNT_W    = 3;
  localparam int unsigned CNT_INIT = (LATENCY >= 2) ? (LATENCY - 2) : 0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic               resp_valid_d;
  logic [31:0]        resp_data_d;
  logic [31:0]        req_count_d;
  logic [15:0]        miss_count_d;
  logic [31:0]        rom_q [DEPTH];

  logic               accept_c;
  logic               capture_c;
  logic [31:0]        rd_addr_c;
  logic [31:0]        rd_off_c;
  logic [AW-1:0]      rd_idx_c;
  logic               rd_hit_c;

  // State, counters and registered response outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q                <= IDLE;
      cnt_q                  <= '0;
      addr_q                 <= '0;
      io_imem_resp_valid     <= 1'b0;
      io_imem_resp_bits_data <= '0;
      req_count              <= '0;
      miss_count             <= '0;
    end else begin
      state_q                <= state_d;
      cnt_q                  <= cnt_d;
      addr_q                 <= addr_d;
      io_imem_resp_valid     <= resp_valid_d;
      io_imem_resp_bits_data <= resp_data_d;
      req_count              <= req_count_d;
      miss_count             <= miss_count_d;
    end
  end

  // ROM storage; reset fills every word with NOP_INSN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rom_q[i] <= NOP_INSN;
      end
    end else if (load_en) begin
      rom_q[load_addr] <= load_data;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    resp_valid_d = 1'b0;
    resp_data_d  = io_imem_resp_bits_data;
    req_count_d  = req_count;
    miss_count_d = miss_count;
    accept_c     = 1'b0;
    capture_c    = 1'b0;
    rd_addr_c    = addr_q;

    case (state_q)
      IDLE, RESP: begin
        accept_c = io_imem_req_valid;
        if (!io_imem_req_valid) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          capture_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      addr_d      = io_imem_req_bits_addr;
      req_count_d = req_count + 32'd1;
      if (LATENCY == 1) begin
        // Single-cycle latency reads straight from the incoming address.
        capture_c = 1'b1;
        rd_addr_c = io_imem_req_bits_addr;
      end else begin
        state_d = WAIT;
        cnt_d   = CNT_W'(CNT_INIT);
      end
    end

    // Response word is captured on the edge entering RESP; a load landing on
    // that same edge is forwarded, so only loads made during RESP itself miss.
    rd_off_c = rd_addr_c - BASE_ADDR;
    rd_idx_c = AW'(rd_off_c >> 2);
    rd_hit_c = (rd_addr_c >= BASE_ADDR) && ((rd_off_c >> 2) < 32'(DEPTH)) &&
               (rd_addr_c[1:0] == 2'b00);

    if (capture_c) begin
      state_d      = RESP;
      resp_valid_d = 1'b1;
      if (rd_hit_c) begin
        if (load_en && (load_addr == rd_idx_c)) begin
          resp_data_d = load_data;
        end else begin
          resp_data_d = rom_q[rd_idx_c];
        end
      end else begin
        resp_data_d = NOP_INSN;
        if (miss_count != 16'hFFFF) begin
          miss_count_d = miss_count + 16'd1;
        end
      end
    end
  end

endmodule
